// File: rtl/rom_pkg.sv
// Shared definitions for the instruction-ROM responder: FSM states, instruction
// field layout, one-hot opcodes and the NOP word.
package rom_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OPC_MSB = 18;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OP1_MSB = 11;
  localparam int unsigned OP1_LSB = 8;
  localparam int unsigned OP2_MSB = 7;
  localparam int unsigned OP2_LSB = 0;

  localparam logic [6:0] OPC_MOV0 = 7'h01;
  localparam logic [6:0] OPC_MOV1 = 7'h02;
  localparam logic [6:0] OPC_MOV2 = 7'h04;
  localparam logic [6:0] OPC_ADD  = 7'h08;
  localparam logic [6:0] OPC_SUB  = 7'h10;
  localparam logic [6:0] OPC_JMP  = 7'h20;
  localparam logic [6:0] OPC_JZ   = 7'h40;

  localparam logic [18:0] INST_NOP = 19'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [3:0] op1;
    logic [7:0] op2;
  } inst_t;

  function automatic inst_t make_inst(input logic [6:0] opc, input logic [3:0] op1,
                                      input logic [7:0] op2);
    inst_t w;
    w.opcode = opc;
    w.op1    = op1;
    w.op2    = op2;
    return w;
  endfunction

endpackage

// File: rtl/inst_rom_array.sv
// Instruction store: synchronous write, combinational read at the given address.
// No reset, so contents survive a responder reset.
module inst_rom_array #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read sampled on the write edge sees the word from before that edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_responder.sv
// Responder for the controller's instruction-ROM read handshake with program-load port.
// Optional ROM_PARITY_EN adds a stored even-parity bit, a read check and sticky o_PAR_ERR.
module inst_rom_responder
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned INST_W  = 19,
  parameter int unsigned LATENCY = 2
) (
  input  logic              i_SCLK,
  input  logic              i_RESETB,
  input  logic              i_RD_RQST,
  input  logic [ADDR_W-1:0] i_ADDR,
  output logic              o_ROM_READY,
  output logic [INST_W-1:0] o_INST,
  output logic              o_BUSY,
  input  logic              i_PRG_WE,
  input  logic [ADDR_W-1:0] i_PRG_ADDR,
  input  logic [INST_W-1:0] i_PRG_DATA
`ifdef ROM_PARITY_EN
  ,
  output logic              o_PAR_ERR
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("inst_rom_responder: LATENCY must be within 1..15");
  end

`ifdef ROM_PARITY_EN
  localparam int unsigned ARR_W = INST_W + 1;
`else
  localparam int unsigned ARR_W = INST_W;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_d;
  logic [INST_W-1:0] inst_d;
  logic [ARR_W-1:0]  wr_word, rd_word;
`ifdef ROM_PARITY_EN
  logic              par_err_d;

  assign wr_word = {^i_PRG_DATA, i_PRG_DATA};
`else
  assign wr_word = i_PRG_DATA;
`endif

  inst_rom_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (ARR_W)
  ) u_array (
    .clk   (i_SCLK),
    .we    (i_PRG_WE),
    .waddr (i_PRG_ADDR),
    .wdata (wr_word),
    .raddr (addr_q),
    .rdata (rd_word)
  );

  // Next-state, counter, latched address and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ready_d = 1'b0;
    inst_d  = o_INST;
`ifdef ROM_PARITY_EN
    par_err_d = o_PAR_ERR;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!i_RD_RQST) begin
          addr_d  = i_ADDR;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        ready_d = 1'b1;
        inst_d  = rd_word[INST_W-1:0];
`ifdef ROM_PARITY_EN
        if (^rd_word) begin
          inst_d    = INST_W'(INST_NOP);
          par_err_d = 1'b1;
        end
`endif
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // A request still held low here belongs to the transaction just answered.
        if (i_RD_RQST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      o_ROM_READY <= 1'b0;
      o_INST      <= '0;
      o_BUSY      <= 1'b0;
`ifdef ROM_PARITY_EN
      o_PAR_ERR   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      o_ROM_READY <= ready_d;
      o_INST      <= inst_d;
      o_BUSY      <= (state_d != ST_IDLE);
`ifdef ROM_PARITY_EN
      o_PAR_ERR   <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Self-checking bench for inst_rom_responder: directed handshake cases plus random reads
// against a word-level reference store. Covers ROM_PARITY_EN when that macro is defined.
module tb_inst_rom_responder;
  import rom_pkg::*;

  localparam int unsigned AW  = 7;
  localparam int unsigned IW  = 19;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rqst;
  logic [AW-1:0] addr;
  logic          ready;
  logic [IW-1:0] inst;
  logic          busy;
  logic          we;
  logic [AW-1:0] paddr;
  logic [IW-1:0] pdata;
`ifdef ROM_PARITY_EN
  logic          par_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [IW-1:0] ref_mem [2**AW];
  logic          par_err_exp = 1'b0;

  inst_rom_responder #(.ADDR_W(AW), .INST_W(IW), .LATENCY(LAT)) dut (
    .i_SCLK      (clk),
    .i_RESETB    (rst_n),
    .i_RD_RQST   (rqst),
    .i_ADDR      (addr),
    .o_ROM_READY (ready),
    .o_INST      (inst),
    .o_BUSY      (busy),
    .i_PRG_WE    (we),
    .i_PRG_ADDR  (paddr),
    .i_PRG_DATA  (pdata)
`ifdef ROM_PARITY_EN
    ,
    .o_PAR_ERR   (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_par(input string tag);
`ifdef ROM_PARITY_EN
    chk({tag, "_parerr"}, 32'(par_err), 32'(par_err_exp));
`endif
  endtask

  // Program one word through the port; called at a negedge, returns at the next one.
  task automatic prg(input logic [AW-1:0] a, input logic [IW-1:0] d);
    we = 1'b1; paddr = a; pdata = d;
    @(negedge clk);
    we = 1'b0;
    ref_mem[a] = d;
  endtask

  // One read transaction from IDLE. Optionally writes on the response edge and/or
  // changes i_ADDR right after acceptance. Expected word is the store content
  // before the response edge, or NOP when a parity error is expected.
  task automatic rd(input string tag, input logic [AW-1:0] a, input int hold_low,
                    input bit do_wr, input logic [AW-1:0] wa, input logic [IW-1:0] wd,
                    input bit chg, input logic [AW-1:0] na, input bit exp_err);
    logic [IW-1:0] exp;
    int seen;
    exp  = exp_err ? '0 : ref_mem[a];
    seen = -1;
    rqst = 1'b0; addr = a;
    for (int i = 1; i <= int'(LAT) + 3 && seen < 0; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (ready) seen = i - 1;
      if (chg && i == 1) addr = na;
      if (do_wr && i == int'(LAT)) begin
        we = 1'b1; paddr = wa; pdata = wd;
        ref_mem[wa] = wd;
      end else begin
        we = 1'b0;
      end
    end
    we = 1'b0;
    if (exp_err) par_err_exp = 1'b1;
    chk({tag, "_lat"}, 32'(seen), 32'(LAT));
    chk({tag, "_inst"}, 32'(inst), 32'(exp));
    chk_par(tag);
    for (int h = 0; h < hold_low; h++) begin
      @(negedge clk);
      chk({tag, "_nopulse"}, 32'(ready), 32'd0);
      chk({tag, "_hold_inst"}, 32'(inst), 32'(exp));
    end
    rqst = 1'b1; addr = AW'($urandom);
    @(negedge clk);
    chk({tag, "_rdy_low"}, 32'(ready), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_inst"}, 32'(inst), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; rqst = 1'b1; addr = '0; we = 1'b0; paddr = '0; pdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_par("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 2**AW; a++) prg(AW'(a), IW'($urandom));
    prg(7'd0, make_inst(OPC_MOV0, 4'd3, 8'h05));
    prg(7'd4, make_inst(OPC_SUB, 4'd1, 8'h02));

    // Basic read, request held low after ready, then next request
    rd("basic", 7'd0, 3, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    rd("next", 7'd1, 1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    // Write on the response edge to the same address returns the old word
    rd("wr_same", 7'd4, 1, 1'b1, 7'd4, make_inst(OPC_JZ, 4'd0, 8'h02), 1'b0, '0, 1'b0);
    rd("wr_new", 7'd4, 1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    // Address change after acceptance is ignored
    rd("addr_chg", 7'd7, 1, 1'b0, '0, '0, 1'b1, 7'd9, 1'b0);

    // Reset during WAIT
    rqst = 1'b0; addr = 7'd5;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_inst", 32'(inst), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    par_err_exp = 1'b0;
    @(negedge clk);
    rqst = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(negedge clk);
      chk("midrst_nopulse", 32'(ready), 32'd0);
    end
    chk("midrst_inst_after", 32'(inst), 32'd0);
    rd("after_rst", 7'd5, 1, 1'b0, '0, '0, 1'b0, '0, 1'b0);

`ifdef ROM_PARITY_EN
    dut.u_array.mem[2][IW] = ~dut.u_array.mem[2][IW];
    rd("par_bad", 7'd2, 1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    rd("par_sticky", 7'd3, 1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    par_err_exp = 1'b0;
    chk_par("par_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // Random reads with random hold lengths and occasional response-edge writes
    for (int k = 0; k < 24; k++) begin
      logic [AW-1:0] ra;
      logic [AW-1:0] wa;
      bit            dw;
      ra = AW'($urandom);
`ifdef ROM_PARITY_EN
      if (ra == 7'd2) ra = 7'd6;
`endif
      dw = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 1) == 0) ? ra : AW'($urandom);
`ifdef ROM_PARITY_EN
      if (wa == 7'd2) wa = 7'd6;
`endif
      rd("rand", ra, $urandom_range(0, 3), dw, wa, IW'($urandom), 1'b0, '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
